// File: rtl/scc_z8530.sv
// Zilog 8530 SCC register-compatible subset for the IIgs C038-C03B window.
// The pointer-based register file and DCD ext/status interrupts are modelled; the serial datapath is stubbed.
module scc_z8530 (
    input  logic       clk_14m,
    input  logic       reset,
    input  logic       cep,
    input  logic       cen,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] rs,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq_n,
    input  logic       rxd,
    output logic       txd,
    input  logic       cts,
    output logic       rts,
    input  logic       dcd_a,
    input  logic       dcd_b,
    output logic       wreq
);

    // Channel index 1 = A, 0 = B throughout (matches rs[0]).
    logic [3:0]      ptr;
    logic [1:0][7:0] wr1, wr5, wr15, wr12, wr13;
    logic [7:0]      wr2, wr9;
    logic [1:0]      tx_ip, ext_ip, dcd_l;

    logic       acc, wr_ctl, wr_dat, rd_ctl, ctl_acc, wr0, reg_wr, hw_rst;
    logic [1:0] sel, chan_rst, dcd_pin;
    logic [2:0] cmd, status;
    logic [7:0] rr2_b;

    assign acc      = cs & cep;
    assign wr_ctl   = acc & we & ~rs[1];
    assign wr_dat   = acc & we & rs[1];
    assign rd_ctl   = acc & ~we & ~rs[1];
    assign ctl_acc  = wr_ctl | rd_ctl;
    assign cmd      = wdata[5:3];
    assign wr0      = wr_ctl & (ptr == 4'd0);
    assign reg_wr   = wr_ctl & (ptr != 4'd0);
    assign hw_rst   = reg_wr & (ptr == 4'd9) & (wdata[7:6] == 2'b11);
    assign chan_rst = {reg_wr & (ptr == 4'd9) & (wdata[7:6] == 2'b10),
                       reg_wr & (ptr == 4'd9) & (wdata[7:6] == 2'b01)};
    assign sel      = rs[0] ? 2'b10 : 2'b01;
    assign dcd_pin  = {dcd_a, dcd_b};

    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            wr1    <= '0;
            wr5    <= '0;
            wr15   <= '0;
            wr12   <= '0;
            wr13   <= '0;
            wr2    <= '0;
            wr9    <= '0;
            tx_ip  <= '0;
            ext_ip <= '0;
            dcd_l  <= dcd_pin;
        end else if (hw_rst) begin
            ptr    <= '0;
            wr1    <= '0;
            wr5    <= '0;
            wr15   <= '0;
            wr12   <= '0;
            wr13   <= '0;
            wr2    <= '0;
            wr9    <= '0;
            tx_ip  <= '0;
            ext_ip <= '0;
            dcd_l  <= dcd_pin;
        end else begin
            // WR0 "point high" (001) selects registers 8-15.
            if (wr0)
                ptr <= {cmd == 3'b001, wdata[2:0]};
            else if (ctl_acc)
                ptr <= '0;

            if (reg_wr) begin
                case (ptr)
                    4'd1:    wr1[rs[0]]  <= wdata;
                    4'd2:    wr2         <= wdata;
                    4'd5:    wr5[rs[0]]  <= wdata;
                    4'd9:    wr9         <= wdata;
                    4'd12:   wr12[rs[0]] <= wdata;
                    4'd13:   wr13[rs[0]] <= wdata;
                    4'd15:   wr15[rs[0]] <= wdata;
                    default: ;
                endcase
            end

            for (int i = 0; i < 2; i++) begin
                // DCD follows the pin until an ext/status interrupt freezes it.
                if (cen && !ext_ip[i] && (dcd_pin[i] != dcd_l[i])) begin
                    dcd_l[i] <= dcd_pin[i];
                    if (wr1[i][0] && wr15[i][3])
                        ext_ip[i] <= 1'b1;
                end
                if (wr_dat && sel[i] && wr1[i][1])
                    tx_ip[i] <= 1'b1;
                if (wr0 && sel[i] && (cmd == 3'b101))
                    tx_ip[i] <= 1'b0;
                // Placed after the DCD sampling so a coincident reset ext/status wins.
                if (wr0 && sel[i] && (cmd == 3'b010)) begin
                    ext_ip[i] <= 1'b0;
                    dcd_l[i]  <= dcd_pin[i];
                end
                if (chan_rst[i]) begin
                    wr1[i]    <= '0;
                    wr5[i]    <= '0;
                    wr15[i]   <= '0;
                    tx_ip[i]  <= 1'b0;
                    ext_ip[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        status = 3'b011;
        if (tx_ip[1])       status = 3'b100;
        else if (ext_ip[1]) status = 3'b101;
        else if (tx_ip[0])  status = 3'b000;
        else if (ext_ip[0]) status = 3'b001;
    end

    always_comb begin
        rr2_b = wr2;
        if (wr9[0] && !wr9[4])
            rr2_b[3:1] = status;
        else if (wr9[0] && wr9[4])
            rr2_b[6:4] = {status[0], status[1], status[2]};
    end

    always_comb begin
        rdata = 8'h00;
        if (!rs[1]) begin
            case (ptr)
                4'd0:    rdata = {1'b0, 1'b1, rs[0] ? cts : 1'b1, 1'b0, dcd_l[rs[0]], 1'b1, 2'b00};
                4'd1:    rdata = 8'h07;
                4'd2:    rdata = rs[0] ? wr2 : rr2_b;
                4'd3:    rdata = rs[0] ? {3'b000, tx_ip[1], ext_ip[1], 1'b0, tx_ip[0], ext_ip[0]} : 8'h00;
                4'd12:   rdata = wr12[rs[0]];
                4'd13:   rdata = wr13[rs[0]];
                4'd15:   rdata = wr15[rs[0]];
                default: rdata = 8'h00;
            endcase
        end
    end

    assign irq_n = ~(wr9[3] & (|{tx_ip, ext_ip}));
    assign txd   = 1'b1;
    assign rts   = ~wr5[1][1];
    assign wreq  = wr1[1][7] & wr1[1][6];

    logic unused_bits;
    assign unused_bits = &{1'b0, rxd, wr9[7:5], wr9[2:1], wr5[1][7:2], wr5[1][0], wr5[0],
                           wr1[0][7:2], wr1[1][5:2]};

endmodule

// File: tb/tb_scc_z8530.sv
// Bench for scc_z8530: directed scenarios plus a random register/interrupt walk
// checked against a register-array model of the SCC.
module tb_scc_z8530;

    logic       clk_14m = 1'b0;
    logic       reset, cep, cen, cs, we;
    logic [1:0] rs;
    logic [7:0] wdata, rdata;
    logic       irq_n, rxd, txd, cts, rts, dcd_a, dcd_b, wreq;

    int checks = 0;
    int errors = 0;

    scc_z8530 dut (
        .clk_14m(clk_14m), .reset(reset), .cep(cep), .cen(cen), .cs(cs), .we(we),
        .rs(rs), .wdata(wdata), .rdata(rdata), .irq_n(irq_n), .rxd(rxd), .txd(txd),
        .cts(cts), .rts(rts), .dcd_a(dcd_a), .dcd_b(dcd_b), .wreq(wreq)
    );

    always #35 clk_14m = ~clk_14m;

    // ---------------- reference model (channel 1 = A, 0 = B) ----------------
    logic [7:0] m_wr [0:1][0:15];
    int         m_ptr;
    logic       m_tx  [0:1];
    logic       m_ext [0:1];
    logic       m_dcd [0:1];

    function automatic logic pin(input int ch);
        return (ch == 1) ? dcd_a : dcd_b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 16; r++) m_wr[c][r] = 8'h00;
            m_tx[c]  = 1'b0;
            m_ext[c] = 1'b0;
            m_dcd[c] = pin(c);
        end
        m_ptr = 0;
    endtask

    task automatic model_clear_chan(input int ch);
        m_wr[ch][1]  = 8'h00;
        m_wr[ch][5]  = 8'h00;
        m_wr[ch][15] = 8'h00;
        m_tx[ch]     = 1'b0;
        m_ext[ch]    = 1'b0;
    endtask

    task automatic model_ctrl_write(input int ch, input logic [7:0] d);
        int r;
        if (m_ptr == 0) begin
            if (d[5:3] == 3'd2) begin
                m_ext[ch] = 1'b0;
                m_dcd[ch] = pin(ch);
            end
            if (d[5:3] == 3'd5) m_tx[ch] = 1'b0;
            m_ptr = int'(d[2:0]) + ((d[5:3] == 3'd1) ? 8 : 0);
        end else begin
            r = m_ptr;
            m_ptr = 0;
            if (r == 2 || r == 9) begin
                m_wr[0][r] = d;
                m_wr[1][r] = d;
            end else begin
                m_wr[ch][r] = d;
            end
            if (r == 9) begin
                if (d[7:6] == 2'b11)      model_reset();
                else if (d[7:6] == 2'b10) model_clear_chan(1);
                else if (d[7:6] == 2'b01) model_clear_chan(0);
            end
        end
    endtask

    task automatic model_cen();
        for (int c = 0; c < 2; c++) begin
            if (!m_ext[c] && (pin(c) !== m_dcd[c])) begin
                m_dcd[c] = pin(c);
                if (m_wr[c][1][0] && m_wr[c][15][3]) m_ext[c] = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] model_read(input int ch, input logic is_data);
        logic [7:0] v;
        logic [2:0] code;
        logic       pend [4];
        int         pcode [4];
        v = 8'h00;
        if (is_data) return 8'h00;
        case (m_ptr)
            0: begin
                v = 8'h44;
                if (ch == 0 || cts) v = v | 8'h20;
                if (m_dcd[ch]) v = v | 8'h08;
            end
            1: v = 8'h07;
            2: begin
                v = m_wr[0][2];
                if (ch == 0 && m_wr[0][9][0]) begin
                    pend[0] = m_tx[1];  pcode[0] = 4;
                    pend[1] = m_ext[1]; pcode[1] = 5;
                    pend[2] = m_tx[0];  pcode[2] = 0;
                    pend[3] = m_ext[0]; pcode[3] = 1;
                    code = 3'd3;
                    for (int k = 0; k < 4; k++) begin
                        if (pend[k]) begin
                            code = 3'(pcode[k]);
                            break;
                        end
                    end
                    if (!m_wr[0][9][4]) begin
                        v[3:1] = code;
                    end else begin
                        v[4] = code[2];
                        v[5] = code[1];
                        v[6] = code[0];
                    end
                end
            end
            3: if (ch == 1) v = 8'({m_tx[1], m_ext[1], 1'b0, m_tx[0], m_ext[0]});
            12, 13, 15: v = m_wr[ch][m_ptr];
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic exp_irq_n();
        return ~(m_wr[0][9][3] & (m_tx[0] | m_tx[1] | m_ext[0] | m_ext[1]));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic is_data, input int ch, input logic [7:0] d);
        @(negedge clk_14m);
        cs = 1'b1; we = 1'b1; rs = {is_data, ch[0]}; wdata = d;
        @(negedge clk_14m);
        cs = 1'b0; we = 1'b0;
        if (cep) begin
            if (is_data) begin
                if (m_wr[ch][1][1]) m_tx[ch] = 1'b1;
            end else begin
                model_ctrl_write(ch, d);
            end
        end
    endtask

    task automatic bus_read(input logic is_data, input int ch, output logic [7:0] v);
        @(negedge clk_14m);
        cs = 1'b1; we = 1'b0; rs = {is_data, ch[0]};
        #1 v = rdata;
        @(negedge clk_14m);
        cs = 1'b0;
        if (cep && !is_data) m_ptr = 0;
    endtask

    task automatic point(input int ch, input int r);
        bus_write(1'b0, ch, 8'((r & 7) | ((r >= 8) ? 8 : 0)));
    endtask

    task automatic pulse_cen();
        @(negedge clk_14m);
        cen = 1'b1;
        @(negedge clk_14m);
        cen = 1'b0;
        model_cen();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_14m);
        reset = 1'b0;
        model_reset();
        @(negedge clk_14m);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] got, exp;
        apply_reset();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL reset_rts got=%b exp=1", rts); end
        checks++; if (wreq !== 1'b0) begin errors++; $display("FAIL reset_wreq got=%b exp=0", wreq); end
        exp = model_read(0, 1'b0);
        bus_read(1'b0, 0, got);
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_rr0_b got=%h exp=%h", got, exp); end
        checks++; if (got[2] !== 1'b1 || got[6] !== 1'b1) begin errors++; $display("FAIL reset_rr0_bits got=%h exp=x1xxx1xx", got); end
    endtask

    task automatic test_pointer();
        logic [7:0] got, exp;
        bus_write(1'b0, 0, 8'h02);
        bus_write(1'b0, 0, 8'h5A);
        bus_write(1'b0, 0, 8'h02);
        exp = model_read(0, 1'b0);
        bus_read(1'b0, 0, got);
        checks++; if (got !== 8'h5A || got !== exp) begin errors++; $display("FAIL ptr_rr2 got=%h exp=%h", got, exp); end
        exp = model_read(0, 1'b0);
        bus_read(1'b0, 0, got);
        checks++; if (got !== exp) begin errors++; $display("FAIL ptr_back_to_rr0 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_tx_irq();
        logic [7:0] got, exp;
        point(1, 9); bus_write(1'b0, 1, 8'h09);
        point(1, 1); bus_write(1'b0, 1, 8'h02);
        bus_write(1'b1, 1, 8'h41);
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL tx_irq_set got=%b exp=0", irq_n); end
        point(1, 3);
        bus_read(1'b0, 1, got);
        checks++; if (got !== 8'h10) begin errors++; $display("FAIL tx_rr3a got=%h exp=10", got); end
        point(0, 2);
        exp = model_read(0, 1'b0);
        bus_read(1'b0, 0, got);
        checks++; if (got[3:1] !== 3'b100 || got !== exp) begin errors++; $display("FAIL tx_rr2b got=%h exp=%h", got, exp); end
        bus_write(1'b0, 1, 8'h28);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL tx_irq_clear got=%b exp=1", irq_n); end
    endtask

    task automatic test_dcd();
        logic [7:0] got;
        point(0, 15); bus_write(1'b0, 0, 8'h08);
        point(0, 1);  bus_write(1'b0, 0, 8'h01);
        point(1, 9);  bus_write(1'b0, 1, 8'h08);
        dcd_b = 1'b0;
        pulse_cen();
        point(1, 3);
        bus_read(1'b0, 1, got);
        checks++; if (got !== 8'h01) begin errors++; $display("FAIL dcd_rr3a got=%h exp=01", got); end
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL dcd_irq_set got=%b exp=0", irq_n); end
        dcd_b = 1'b1;
        pulse_cen();
        bus_read(1'b0, 0, got);
        checks++; if (got[3] !== 1'b0) begin errors++; $display("FAIL dcd_frozen got=%b exp=0", got[3]); end
        bus_write(1'b0, 0, 8'h10);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL dcd_irq_clear got=%b exp=1", irq_n); end
        bus_read(1'b0, 0, got);
        checks++; if (got[3] !== 1'b1) begin errors++; $display("FAIL dcd_relatch got=%b exp=1", got[3]); end
    endtask

    task automatic test_hw_reset();
        logic [7:0] got, exp;
        point(1, 1); bus_write(1'b0, 1, 8'hC2);
        bus_write(1'b1, 1, 8'h55);
        checks++; if (irq_n !== 1'b0 || wreq !== 1'b1) begin errors++; $display("FAIL hwr_pre got=%b%b exp=01", irq_n, wreq); end
        point(1, 9); bus_write(1'b0, 1, 8'hC0);
        checks++; if (irq_n !== 1'b1 || wreq !== 1'b0) begin errors++; $display("FAIL hwr_outputs got=%b%b exp=10", irq_n, wreq); end
        point(1, 3);
        bus_read(1'b0, 1, got);
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL hwr_rr3a got=%h exp=00", got); end
        point(0, 2);
        exp = model_read(0, 1'b0);
        bus_read(1'b0, 0, got);
        checks++; if (got !== 8'h00 || got !== exp) begin errors++; $display("FAIL hwr_rr2b got=%h exp=%h", got, exp); end
    endtask

    task automatic test_no_cep();
        logic [7:0] got, exp;
        point(1, 1); bus_write(1'b0, 1, 8'h02);
        point(1, 9); bus_write(1'b0, 1, 8'h08);
        cep = 1'b0;
        bus_write(1'b0, 0, 8'h03);
        bus_write(1'b1, 1, 8'h99);
        cep = 1'b1;
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL nocep_irq got=%b exp=1", irq_n); end
        exp = model_read(0, 1'b0);
        bus_read(1'b0, 0, got);
        checks++; if (got !== exp) begin errors++; $display("FAIL nocep_ptr got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        point(1, 3);
        @(negedge clk_14m);
        cs = 1'b1; we = 1'b0; rs = 2'b01; reset = 1'b1;
        @(negedge clk_14m);
        cs = 1'b0; reset = 1'b0;
        model_reset();
        exp = model_read(1, 1'b0);
        bus_read(1'b0, 1, got);
        checks++; if (got !== exp) begin errors++; $display("FAIL rstmid_rr0 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] got, exp;
        point(1, 15); bus_write(1'b0, 1, 8'h08);
        point(1, 1);  bus_write(1'b0, 1, 8'h01);
        point(1, 9);  bus_write(1'b0, 1, 8'h08);
        @(negedge clk_14m);
        dcd_a = ~dcd_a; cen = 1'b1;
        cs = 1'b1; we = 1'b1; rs = 2'b01; wdata = 8'h10;
        @(negedge clk_14m);
        cs = 1'b0; we = 1'b0; cen = 1'b0;
        model_ctrl_write(1, 8'h10);
        model_cen();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL simul_irq got=%b exp=1", irq_n); end
        exp = model_read(1, 1'b0);
        bus_read(1'b0, 1, got);
        checks++; if (got !== exp) begin errors++; $display("FAIL simul_rr0a got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        int         wregs [7] = '{1, 2, 5, 9, 12, 13, 15};
        int         rregs [8] = '{0, 1, 2, 3, 7, 12, 13, 15};
        int         op, ch, r;
        logic [7:0] got, exp;
        for (int it = 0; it < 300; it++) begin
            cts = 1'($urandom_range(0, 1));
            op  = $urandom_range(0, 5);
            ch  = $urandom_range(0, 1);
            case (op)
                0: begin
                    r = wregs[$urandom_range(0, 6)];
                    point(ch, r);
                    bus_write(1'b0, ch, 8'($urandom_range(0, 255)));
                end
                1: bus_write(1'b1, ch, 8'($urandom_range(0, 255)));
                2: begin
                    r = rregs[$urandom_range(0, 7)];
                    if (r != 0) point(ch, r);
                    exp = model_read(ch, 1'b0);
                    bus_read(1'b0, ch, got);
                    checks++; if (got !== exp) begin errors++; $display("FAIL rnd_read it=%0d ch=%0d reg=%0d got=%h exp=%h", it, ch, r, got, exp); end
                end
                3: begin
                    if (ch == 1) dcd_a = 1'($urandom_range(0, 1));
                    else         dcd_b = 1'($urandom_range(0, 1));
                    pulse_cen();
                end
                4: bus_write(1'b0, ch, ($urandom_range(0, 1) == 1) ? 8'h10 : 8'h28);
                default: begin
                    bus_read(1'b1, ch, got);
                    checks++; if (got !== 8'h00) begin errors++; $display("FAIL rnd_data_read it=%0d got=%h exp=00", it, got); end
                end
            endcase
            checks++; if (irq_n !== exp_irq_n()) begin errors++; $display("FAIL rnd_irq_n it=%0d got=%b exp=%b", it, irq_n, exp_irq_n()); end
            checks++; if (rts !== ~m_wr[1][5][1]) begin errors++; $display("FAIL rnd_rts it=%0d got=%b exp=%b", it, rts, ~m_wr[1][5][1]); end
            checks++; if (wreq !== (m_wr[1][1][7] & m_wr[1][1][6])) begin errors++; $display("FAIL rnd_wreq it=%0d got=%b", it, wreq); end
        end
    endtask

    initial begin
        reset = 1'b1; cep = 1'b1; cen = 1'b0; cs = 1'b0; we = 1'b0;
        rs = 2'b00; wdata = 8'h00; rxd = 1'b1; cts = 1'b0;
        dcd_a = 1'b1; dcd_b = 1'b1;
        test_reset();
        test_pointer();
        test_tx_irq();
        test_dcd();
        test_hw_reset();
        test_no_cep();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scc_z8530.md
Name: scc_z8530

Overview:
Dual-channel serial communications controller, a register-compatible subset of the Zilog 8530. It sits behind the Apple IIgs C038–C03B decode and exposes the 8530 pointer-based control and data registers to the CPU. It provides an interrupt output and DCD external/status interrupts for the mouse. Serial transmit and receive are stubbed: the transmitter is always ready and no receive path exists.

Parameters:
None.

Ports:
clk_14m  input  1  14.32 MHz master clock
reset  input  1  asynchronous, active-high; clears all state
cep  input  1  bus/positive-phase clock enable; all register side effects happen on clk_14m edges with cep=1
cen  input  1  negative-phase enable; DCD inputs are sampled on cen
cs  input  1  chip select
we  input  1  1=write, 0=read
rs  input  2  rs[1]: 1=data, 0=control; rs[0]: 1=channel A, 0=channel B
wdata  input  8  write data
rdata  output  8  read data, combinational from rs and the current pointer
irq_n  output  1  active-low interrupt
rxd  input  1  channel A receive (ignored)
txd  output  1  channel A transmit; constant 1 (mark)
cts  input  1  channel A CTS pin
rts  output  1  ~WR5A[1]
dcd_a  input  1  channel A DCD pin
dcd_b  input  1  channel B DCD pin
wreq  output  1  WR1A[7] & WR1A[6] & TxEmpty (TxEmpty is always 1)

Behaviour:
- Access strobe: acc = cs & cep. Write when acc & we; read side effects when acc & ~we.
- Register pointer:
  - One 4-bit pointer, shared by both channels.
  - A control write while the pointer is 0 writes WR0: pointer <= wdata[2:0] | (wdata[5:3]==001 ? 8 : 0).
  - Any other control access (read, or write with pointer≠0) uses the pointer and then returns the pointer to 0.
- Per-channel write registers kept: WR1, WR5, WR15. Shared: WR2 (vector) and WR9. WR3/4/6/7/10–14 are accepted and stored only if needed for readback; otherwise they are ignored.
- WR0 commands (wdata[5:3]):
  - 010: reset ext/status — clear the channel's Ext IP and re-latch its DCD.
  - 101: reset Tx IP.
  - 111: reset highest IUS (no-op).
- WR9[7:6] commands:
  - 11: hardware reset — same as the reset input.
  - 10: channel A reset — WR1A/WR5A/WR15A and A IPs to 0.
  - 01: channel B reset.
- WR9 fields: [3] = MIE; [0] = VIS; [4] = status high/low.
- Data write: if WR1[1] (Tx IE), set that channel's Tx IP.
- Data read returns 0x00.
- DCD: sampled on cen.
  - A change on a channel's DCD while WR1[0] & WR15[3] are set sets that channel's Ext IP and latches the DCD value.
  - Further changes are not re-latched until reset ext/status.
- RR0 fields: [0]=0 (Rx avail), [2]=1 (Tx empty), [3]=latched DCD, [5]=cts (channel A) / 1 (channel B), [6]=1.
- RR1 = 0x07.
- RR2:
  - Channel A returns WR2.
  - Channel B returns WR2 with status bits inserted: bits[3:1] if VIS & ~WR9[4], bits[6:4] reversed if VIS & WR9[4].
- Status codes: B Tx 000, B ext 001, B Rx 010, none 011, A Tx 100, A ext 101, A Rx 110.
- Status priority: A Rx > A Tx > A ext > B Rx > B Tx > B ext.
- RR3: channel A = {2'b0, ARx, ATx, AExt, BRx, BTx, BExt}; channel B reads 0. Rx IPs are always 0.
- RR12/RR13 return the stored WR12/WR13; RR15 returns WR15; other registers read 0.
- irq_n = ~(MIE & any IP). Combinational from registers; changes one clock after the causing strobe.
- Reset values: pointer 0, all WR 0, all IPs 0, latched DCD = current pin value. Outputs after reset: irq_n=1, txd=1, rts=1, wreq=0.
- Simultaneous events: a DCD change and reset ext/status in the same cycle — the reset wins and re-latches the new value. Reset asserted mid-access aborts the access.

Test Plan:
- After reset, control read of channel B → rdata bit2=1, bit6=1; irq_n=1; pointer at 0.
- Write ctrl B 0x02 then 0x5A, write ctrl B 0x02, read ctrl B → 0x5A with VIS=0. The next read returns RR0 (pointer back to 0).
- Write WR9=0x09, WR1A=0x02, write data A 0x41 → irq_n=0. Read RR3 on A → 0x10. Read RR2 on B → bits[3:1]=100. Write ctrl A 0x28 → irq_n=1.
- Write WR15B=0x08, WR1B=0x01, MIE on, toggle dcd_b 1→0 on a cen → RR3A=0x01, irq_n=0. Read RR0 on B → bit3=0. Write ctrl B 0x10 → IP cleared, irq_n=1.
- With IPs pending, write WR9=0xC0 → all IPs and MIE cleared, irq_n=1. Register reads are back to reset values.
- Access with cs=1 but cep=0 → no pointer change and no IP change. Assert reset during a pending pointer → the next control read returns RR0.
